// File: rtl/sign_narrow_16to10.sv
// rtl/sign_narrow_16to10.sv - two-stage signed 16-to-10-bit saturating narrowing pipeline
// Optional saturation event counter is built when NARROW_SAT_CNT_EN is defined.
module sign_narrow_16to10 #(
  parameter int IN_W  = 16,
  parameter int OUT_W = 10,
  parameter int CNT_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [IN_W-1:0]   in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  out_data,
  output logic              out_sat,
  output logic              sat_sticky,
  input  logic              clr_sticky,
  output logic [CNT_W-1:0]  sat_cnt
);

  localparam int HI_W = IN_W - OUT_W + 1;

  localparam logic [OUT_W-1:0] SAT_NEG = {1'b1, {(OUT_W-1){1'b0}}};
  localparam logic [OUT_W-1:0] SAT_POS = {1'b0, {(OUT_W-1){1'b1}}};

  logic              adv;
  logic              accept;
  logic              in_fits;
  logic [HI_W-1:0]   in_hi;

  logic              s1_valid;
  logic              s1_fits;
  logic              s1_sign;
  logic [OUT_W-1:0]  s1_low;

  // A word fits when every bit from the output sign position upward is a copy of the sign.
  assign in_hi    = in_data[IN_W-1:OUT_W-1];
  assign in_fits  = (&in_hi) | ~(|in_hi);

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv || !s1_valid;
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_fits  <= 1'b1;
      s1_sign  <= 1'b0;
      s1_low   <= '0;
    end else begin
      if (accept) begin
        s1_valid <= 1'b1;
        s1_fits  <= in_fits;
        s1_sign  <= in_data[IN_W-1];
        s1_low   <= in_data[OUT_W-1:0];
      end else if (adv) begin
        s1_valid <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sat   <= 1'b0;
    end else if (adv) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        if (s1_fits) begin
          out_data <= s1_low;
          out_sat  <= 1'b0;
        end else begin
          out_data <= s1_sign ? SAT_NEG : SAT_POS;
          out_sat  <= 1'b1;
        end
      end
    end
  end

  // Set takes priority over clear so a saturation in the clearing cycle is never lost.
  always_ff @(posedge clk) begin
    if (rst) begin
      sat_sticky <= 1'b0;
    end else if (accept && !in_fits) begin
      sat_sticky <= 1'b1;
    end else if (clr_sticky) begin
      sat_sticky <= 1'b0;
    end
  end

`ifdef NARROW_SAT_CNT_EN
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (accept && !in_fits && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign sat_cnt = cnt_q;
`else
  assign sat_cnt = '0;
`endif

endmodule

// File: tb/tb_sign_narrow_16to10.sv
// tb/tb_sign_narrow_16to10.sv - scoreboard testbench for sign_narrow_16to10
module tb_sign_narrow_16to10;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [9:0]  out_data;
  logic        out_sat;
  logic        sat_sticky;
  logic        clr_sticky = 1'b0;
  logic [7:0]  sat_cnt;

  int errors = 0;
  int checks = 0;
  logic [10:0] sb[$];

  sign_narrow_16to10 dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_sat(out_sat),
    .sat_sticky(sat_sticky), .clr_sticky(clr_sticky), .sat_cnt(sat_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [10:0] model(input logic [15:0] d);
    int v;
    v = int'($signed(d));
    if (v > 511) return {1'b1, 10'h1FF};
    else if (v < -512) return {1'b1, 10'h200};
    else return {1'b0, d[9:0]};
  endfunction

  // Handshakes are observed mid-cycle, where inputs and registered outputs are stable.
  always @(negedge clk) begin
    if (!rst) begin
      if (in_valid && in_ready) sb.push_back(model(in_data));
      if (out_valid && out_ready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_output: got data=%h sat=%b, expected no output", out_data, out_sat);
        end else begin
          logic [10:0] exp;
          exp = sb.pop_front();
          if ({out_sat, out_data} !== exp) begin
            errors++;
            $display("FAIL scoreboard: got sat=%b data=%h, expected sat=%b data=%h",
                     out_sat, out_data, exp[10], exp[9:0]);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || out_valid) && n < 50) begin
      tick();
      n++;
    end
    checks++;
    if (sb.size() != 0 || out_valid) begin
      errors++;
      $display("FAIL drain_timeout: got pending=%0d out_valid=%b, expected 0 and 0", sb.size(), out_valid);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    checks++;
    if ({out_valid, out_data, out_sat, sat_sticky, sat_cnt, in_ready} !== {1'b0, 10'h0, 1'b0, 1'b0, 8'h0, 1'b1}) begin
      errors++;
      $display("FAIL reset_state: got ov=%b od=%h os=%b st=%b cnt=%0d ir=%b, expected 0 000 0 0 0 1",
               out_valid, out_data, out_sat, sat_sticky, sat_cnt, in_ready);
    end
  endtask

  task automatic test_stream();
    logic [15:0] words [4];
    words = '{16'h0005, 16'hFFFB, 16'h01FF, 16'hFE00};
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = words[i];
      tick();
      if (i == 0) begin
        checks++;
        if (out_valid !== 1'b0) begin
          errors++;
          $display("FAIL latency_early: got out_valid=%b, expected 0", out_valid);
        end
      end else if (i == 1) begin
        checks++;
        if (out_valid !== 1'b1 || out_data !== 10'h005) begin
          errors++;
          $display("FAIL latency_first: got ov=%b od=%h, expected 1 005", out_valid, out_data);
        end
      end
    end
    in_valid = 1'b0;
    drain();
    checks++;
    if (sat_sticky !== 1'b0) begin
      errors++;
      $display("FAIL stream_sticky: got %b, expected 0", sat_sticky);
    end
  endtask

  task automatic test_saturation();
    logic [15:0] words [4];
    logic [7:0]  exp_cnt;
    words = '{16'h0200, 16'h7FFF, 16'hFDFF, 16'h8000};
`ifdef NARROW_SAT_CNT_EN
    exp_cnt = 8'd4;
`else
    exp_cnt = 8'd0;
`endif
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = words[i];
      tick();
    end
    in_valid = 1'b0;
    drain();
    checks++;
    if (sat_sticky !== 1'b1 || sat_cnt !== exp_cnt) begin
      errors++;
      $display("FAIL sat_flags: got sticky=%b cnt=%0d, expected 1 %0d", sat_sticky, sat_cnt, exp_cnt);
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] words [3];
    int widx;
    int n;
    logic rdy;
    words = '{16'h0001, 16'h0002, 16'h0003};
    widx = 0;
    out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      in_valid = 1'b1;
      in_data  = words[widx];
      rdy = in_ready;
      tick();
      if (rdy) widx++;
    end
    checks++;
    if (widx !== 2 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL bp_accept: got accepted=%0d in_ready=%b, expected 2 0", widx, in_ready);
    end
    checks++;
    if (out_valid !== 1'b1 || out_data !== 10'h001) begin
      errors++;
      $display("FAIL bp_hold: got ov=%b od=%h, expected 1 001", out_valid, out_data);
    end
    out_ready = 1'b1;
    n = 0;
    while (widx < 3 && n < 20) begin
      in_data = words[widx];
      rdy = in_ready;
      tick();
      if (rdy) widx++;
      n++;
    end
    in_valid = 1'b0;
    checks++;
    if (widx !== 3) begin
      errors++;
      $display("FAIL bp_release: got accepted=%0d, expected 3", widx);
    end
    drain();
  endtask

  task automatic test_sticky_race();
    out_ready  = 1'b1;
    clr_sticky = 1'b1;
    tick();
    checks++;
    if (sat_sticky !== 1'b0) begin
      errors++;
      $display("FAIL sticky_clear_pre: got %b, expected 0", sat_sticky);
    end
    in_valid = 1'b1;
    in_data  = 16'h4000;
    tick();
    in_valid = 1'b0;
    checks++;
    if (sat_sticky !== 1'b1) begin
      errors++;
      $display("FAIL sticky_race: got %b, expected 1", sat_sticky);
    end
    tick();
    clr_sticky = 1'b0;
    checks++;
    if (sat_sticky !== 1'b0) begin
      errors++;
      $display("FAIL sticky_clear: got %b, expected 0", sat_sticky);
    end
    drain();
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 16'h4000;
    tick();
    tick();
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || sat_sticky !== 1'b1) begin
      errors++;
      $display("FAIL mid_setup: got ov=%b sticky=%b, expected 1 1", out_valid, sat_sticky);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sb.delete();
    checks++;
    if ({out_valid, in_ready, sat_sticky, sat_cnt} !== {1'b0, 1'b1, 1'b0, 8'h0}) begin
      errors++;
      $display("FAIL mid_reset: got ov=%b ir=%b st=%b cnt=%0d, expected 0 1 0 0",
               out_valid, in_ready, sat_sticky, sat_cnt);
    end
    out_ready = 1'b1;
    repeat (5) tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL mid_discard: got out_valid=%b, expected 0", out_valid);
    end
  endtask

  task automatic test_cnt_saturation();
    logic [7:0] exp_cnt;
`ifdef NARROW_SAT_CNT_EN
    exp_cnt = 8'd255;
`else
    exp_cnt = 8'd0;
`endif
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 300; i++) begin
      in_data = (i % 2 == 0) ? 16'h8000 : 16'h7FFF;
      tick();
    end
    in_valid = 1'b0;
    drain();
    checks++;
    if (sat_cnt !== exp_cnt) begin
      errors++;
      $display("FAIL cnt_sat: got %0d, expected %0d", sat_cnt, exp_cnt);
    end
    in_valid = 1'b1;
    in_data  = 16'h0200;
    repeat (3) tick();
    in_valid = 1'b0;
    drain();
    checks++;
    if (sat_cnt !== exp_cnt) begin
      errors++;
      $display("FAIL cnt_hold: got %0d, expected %0d", sat_cnt, exp_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_saturation();
    test_backpressure();
    test_sticky_race();
    test_reset_mid();
    test_cnt_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
